// File: rtl/tuart_pkg.sv
// Shared types and constants for the parametrised UART command receiver.
package tuart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int ERR_FRAME   = 0;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_TIMEOUT = 2;

  // Shortest bit period that still leaves room for three distinct vote cycles.
  localparam int MIN_DIV = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tuart_rx_sampler.sv
// Line synchroniser, per-bit cycle counter and 3-vote majority sampler.
module tuart_rx_sampler
  import tuart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_async_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             restart_i,
  input  logic             run_i,
  output logic             rx_o,
  output logic             start_edge_o,
  output logic             bit_valid_o,
  output logic             bit_val_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic [DIV_W-1:0] mid;

  assign mid = div_i >> 1;

  always_comb begin
    sync1_d = rx_async_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    // The edge cycle itself is count 0, so the counter resumes at 1.
    if (restart_i) begin
      cnt_d = ONE;
    end else if (run_i) begin
      if (cnt_q == mid - ONE) v0_d = sync2_q;
      if (cnt_q == mid)       v1_d = sync2_q;
      cnt_d = (cnt_q == div_i - ONE) ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      v0_q    <= 1'b1;
      v1_q    <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign rx_o         = sync2_q;
  assign start_edge_o = prev_q & ~sync2_q;
  // Third vote is taken live on the decision cycle.
  assign bit_valid_o  = run_i & (cnt_q == mid + ONE);
  assign bit_val_o    = maj3(v0_q, v1_q, sync2_q);

endmodule

// File: rtl/tuart_async_rx_ext.sv
// UART command receiver: frame FSM, word packing, idle timeout and error pulses.
module tuart_async_rx_ext
  import tuart_pkg::*;
#(
  parameter int WORD_BITS    = 8,
  parameter int CMD_WORDS    = 5,
  parameter int DIV_W        = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_async_i,
  input  logic [DIV_W-1:0]               div_i,
  input  logic [1:0]                     parity_i,
  output logic [CMD_WORDS*WORD_BITS-1:0] data_o,
  output logic                           stb_o,
  output logic [2:0]                     err_o
);

  localparam int CMD_W = CMD_WORDS * WORD_BITS;
  localparam int BN_W  = $clog2(WORD_BITS + 1);
  localparam int WC_W  = $clog2(CMD_WORDS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

  rx_state_t          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  parity_mode_t       par_q, par_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [BN_W-1:0]    bitn_q, bitn_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [CMD_W-1:0]   data_q, data_d;
  logic               stb_q, stb_d;
  logic [2:0]         err_q, err_d;
  logic               drop_q, drop_d;
  logic [DIV_W-1:0]   idle_cyc_q, idle_cyc_d;
  logic [TO_W-1:0]    idle_bits_q, idle_bits_d;

  logic               rx_s, start_edge, bit_valid, bit_val;
  logic               restart, run;
  logic [DIV_W-1:0]   div_in_eff;
  parity_mode_t       par_in;
  logic               exp_par;
  logic [CMD_W-1:0]   cmd_shift;

  assign div_in_eff = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
  assign par_in     = (parity_i == PAR_EVEN) ? PAR_EVEN :
                      (parity_i == PAR_ODD)  ? PAR_ODD  : PAR_NONE;
  assign exp_par    = (par_q == PAR_ODD) ? ~^shreg_q : ^shreg_q;
  assign cmd_shift  = (cmd_q << WORD_BITS) | CMD_W'(shreg_q);
  assign run        = (state_q != ST_IDLE) && (state_q != ST_BREAK_WAIT);

  tuart_rx_sampler #(.DIV_W(DIV_W)) u_sampler (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_async_i   (rx_async_i),
    .div_i        (div_q),
    .restart_i    (restart),
    .run_i        (run),
    .rx_o         (rx_s),
    .start_edge_o (start_edge),
    .bit_valid_o  (bit_valid),
    .bit_val_o    (bit_val)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    par_d       = par_q;
    shreg_d     = shreg_q;
    bitn_d      = bitn_q;
    wcnt_d      = wcnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    stb_d       = 1'b0;
    err_d       = '0;
    drop_d      = drop_q;
    idle_cyc_d  = idle_cyc_q;
    idle_bits_d = idle_bits_q;
    restart     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          restart = 1'b1;
          div_d   = div_in_eff;
          par_d   = par_in;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_valid) begin
          bitn_d  = '0;
          drop_d  = 1'b0;
          state_d = bit_val ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_valid) begin
          shreg_d = {bit_val, shreg_q[WORD_BITS-1:1]};
          if (bitn_q == BN_W'(WORD_BITS - 1)) begin
            state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bitn_d = bitn_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_valid) begin
          if (bit_val != exp_par) begin
            err_d[ERR_PARITY] = 1'b1;
            drop_d            = 1'b1;
            wcnt_d            = '0;
            cmd_d             = '0;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_valid) begin
          if (!bit_val) begin
            err_d[ERR_FRAME] = 1'b1;
            wcnt_d           = '0;
            cmd_d            = '0;
            state_d          = ST_BREAK_WAIT;
          end else begin
            state_d = ST_IDLE;
            if (!drop_q) begin
              if (wcnt_q == WC_W'(CMD_WORDS - 1)) begin
                data_d = cmd_shift;
                stb_d  = 1'b1;
                wcnt_d = '0;
                cmd_d  = '0;
              end else begin
                cmd_d  = cmd_shift;
                wcnt_d = wcnt_q + 1'b1;
              end
            end
            // A fast sender's next start edge can land on this very vote cycle.
            if (start_edge) begin
              restart = 1'b1;
              div_d   = div_in_eff;
              par_d   = par_in;
              state_d = ST_START;
            end
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle timer: bit-times measured with the divider of the last frame.
    if (state_q == ST_IDLE && wcnt_q != '0 && !start_edge) begin
      if (idle_cyc_q == div_q - 1'b1) begin
        idle_cyc_d = '0;
        if (idle_bits_q == TO_W'(TIMEOUT_BITS - 1)) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          wcnt_d             = '0;
          cmd_d              = '0;
          idle_bits_d        = '0;
        end else begin
          idle_bits_d = idle_bits_q + 1'b1;
        end
      end else begin
        idle_cyc_d = idle_cyc_q + 1'b1;
      end
    end else begin
      idle_cyc_d  = '0;
      idle_bits_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      div_q       <= DIV_W'(MIN_DIV);
      par_q       <= PAR_NONE;
      shreg_q     <= '0;
      bitn_q      <= '0;
      wcnt_q      <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      stb_q       <= 1'b0;
      err_q       <= '0;
      drop_q      <= 1'b0;
      idle_cyc_q  <= '0;
      idle_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      par_q       <= par_d;
      shreg_q     <= shreg_d;
      bitn_q      <= bitn_d;
      wcnt_q      <= wcnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      idle_cyc_q  <= idle_cyc_d;
      idle_bits_q <= idle_bits_d;
    end
  end

  assign data_o = data_q;
  assign stb_o  = stb_q;
  assign err_o  = err_q;

endmodule
